// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR note-lane playfield.
package ddr_pkg;

  localparam int unsigned DEF_LANES   = 4;
  localparam int unsigned DEF_SLOTS   = 8;
  localparam int unsigned DEF_LANE_X0 = 192;
  localparam int unsigned DEF_LANE_W  = 64;
  localparam int unsigned DEF_ARROW_H = 32;
  localparam int unsigned DEF_SPAWN_Y = 480;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    RETIRE
  } state_e;

  // Index 0 = left (purple), 1 = down (cyan), 2 = up (green), 3 = right (red).
  localparam logic [3:0][23:0] LANE_COLOR = {24'hFF0000, 24'h00FF00, 24'h00FFFF, 24'h800080};
  localparam logic [23:0]      LANE_BG    = 24'h202020;

  function automatic logic [10:0] ext11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/note_lane_fifo.sv
// One lane's circular arrow queue: per-slot Y move/saturate, spawn push and head retire.
module note_lane_fifo
  import ddr_pkg::*;
#(
  parameter int unsigned SLOTS   = DEF_SLOTS,
  parameter int unsigned SPAWN_Y = DEF_SPAWN_Y,
  localparam int unsigned IW     = $clog2(SLOTS)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   push_i,
  input  logic                   move_i,
  input  logic [IW-1:0]          slot_idx_i,
  input  logic [3:0]             speed_i,
  input  logic                   retire_i,
  output logic                   pop_o,
  output logic [IW:0]            count_o,
  output logic [SLOTS-1:0][9:0]  entries_o,
  output logic [SLOTS-1:0]       valid_o
);

  logic [SLOTS-1:0][9:0] y_q, y_d;
  logic [IW-1:0]         head_q, head_d;
  logic [IW-1:0]         tail_q, tail_d;
  logic [IW:0]           count_q, count_d;
  logic [9:0]            y_cur, y_moved, spd10;

  // Slot i is live when its distance from head (mod SLOTS) is below count.
  always_comb begin
    valid_o = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      valid_o[i] = ({1'b0, IW'(IW'(i) - head_q)} < count_q);
    end
  end

  always_comb begin
    spd10   = {6'b0, speed_i};
    y_cur   = y_q[slot_idx_i];
    y_moved = (y_cur <= spd10) ? '0 : (y_cur - spd10);
  end

  always_comb begin
    y_d     = y_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop_o   = retire_i && (count_q != '0) && (y_q[head_q] == '0);

    if (move_i && valid_o[slot_idx_i]) begin
      y_d[slot_idx_i] = y_moved;
    end
    if (push_i) begin
      y_d[tail_q] = 10'(SPAWN_Y);
      tail_d      = tail_q + IW'(1);
      count_d     = count_q + (IW+1)'(1);
    end
    if (pop_o) begin
      head_d  = head_q + IW'(1);
      count_d = count_q - (IW+1)'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      y_q     <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      y_q     <= y_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign entries_o = y_q;

endmodule

// File: rtl/note_lane_renderer.sv
// DDR scrolling-note engine: per-lane arrow queues advanced each vertical blank,
// miss reporting for arrows reaching the top, and registered playfield pixel colour.
module note_lane_renderer
  import ddr_pkg::*;
#(
  parameter int unsigned LANES   = DEF_LANES,
  parameter int unsigned SLOTS   = DEF_SLOTS,
  parameter int unsigned LANE_X0 = DEF_LANE_X0,
  parameter int unsigned LANE_W  = DEF_LANE_W,
  parameter int unsigned ARROW_H = DEF_ARROW_H,
  parameter int unsigned SPAWN_Y = DEF_SPAWN_Y
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             update,
  input  logic [3:0]       speed,
  input  logic             spawn_valid,
  input  logic [1:0]       spawn_lane,
  output logic             spawn_ready,
  output logic             miss_valid,
  output logic [LANES-1:0] miss_mask,
  output logic [7:0]       red,
  output logic [7:0]       green,
  output logic [7:0]       blue
);

  localparam int unsigned IW = $clog2(SLOTS);
  localparam int unsigned LW = $clog2(LANE_W);

  state_e                           state_q, state_d;
  logic                             update_d_q;
  logic                             update_rise;
  logic [3:0]                       speed_q, speed_d;
  logic [IW-1:0]                    slot_idx_q, slot_idx_d;
  logic                             miss_valid_q;
  logic [LANES-1:0]                 miss_mask_q;
  logic [23:0]                      rgb_q, rgb_d;

  logic [LANES-1:0]                 push, pop;
  logic [LANES-1:0][IW:0]           count;
  logic [LANES-1:0][SLOTS-1:0][9:0] entries;
  logic [LANES-1:0][SLOTS-1:0]      valid;
  logic                             move_en, retire_en;

  assign update_rise = update && !update_d_q;
  assign move_en     = (state_q == MOVE);
  assign retire_en   = (state_q == RETIRE);
  assign spawn_ready = (state_q == IDLE) && !update_rise
                       && (count[spawn_lane] != (IW+1)'(SLOTS));

  always_comb begin
    push = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      push[l] = spawn_valid && spawn_ready && (spawn_lane == 2'(l));
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    note_lane_fifo #(
      .SLOTS   (SLOTS),
      .SPAWN_Y (SPAWN_Y)
    ) u_fifo (
      .Clk        (Clk),
      .Reset      (Reset),
      .push_i     (push[g]),
      .move_i     (move_en),
      .slot_idx_i (slot_idx_q),
      .speed_i    (speed_q),
      .retire_i   (retire_en),
      .pop_o      (pop[g]),
      .count_o    (count[g]),
      .entries_o  (entries[g]),
      .valid_o    (valid[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    slot_idx_d = slot_idx_q;
    unique case (state_q)
      IDLE: begin
        if (update_rise) begin
          state_d    = MOVE;
          speed_d    = speed;
          slot_idx_d = '0;
        end
      end
      MOVE: begin
        slot_idx_d = slot_idx_q + IW'(1);
        if (slot_idx_q == IW'(SLOTS - 1)) begin
          state_d = RETIRE;
        end
      end
      RETIRE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [10:0]      x11, y11, rel_x, top11;
  logic             in_region;
  logic [1:0]       lane;
  logic [LANES-1:0] lane_hit;

  // Hit test runs in 11 bits so Y + ARROW_H near the bottom never wraps.
  always_comb begin
    x11       = {1'b0, DrawX};
    y11       = {1'b0, DrawY};
    in_region = (x11 >= 11'(LANE_X0)) && (x11 < 11'(LANE_X0 + LANES * LANE_W));
    rel_x     = x11 - 11'(LANE_X0);
    lane      = 2'(rel_x >> LW);
    lane_hit  = '0;
    top11     = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned s = 0; s < SLOTS; s++) begin
        top11 = ext11(entries[l][s]);
        if (valid[l][s] && (y11 >= top11) && (y11 < top11 + 11'(ARROW_H))) begin
          lane_hit[l] = 1'b1;
        end
      end
    end
    rgb_d = '0;
    if (!update && in_region) begin
      rgb_d = lane_hit[lane] ? LANE_COLOR[lane] : LANE_BG;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      update_d_q   <= 1'b1;
      speed_q      <= '0;
      slot_idx_q   <= '0;
      miss_valid_q <= 1'b0;
      miss_mask_q  <= '0;
      rgb_q        <= '0;
    end else begin
      state_q      <= state_d;
      update_d_q   <= update;
      speed_q      <= speed_d;
      slot_idx_q   <= slot_idx_d;
      miss_valid_q <= |pop;
      miss_mask_q  <= pop;
      rgb_q        <= rgb_d;
    end
  end

  assign miss_valid = miss_valid_q;
  assign miss_mask  = miss_mask_q;
  assign red        = rgb_q[23:16];
  assign green      = rgb_q[15:8];
  assign blue       = rgb_q[7:0];

endmodule

// File: tb/tb_note_lane_renderer.sv
// Scoreboard bench for note_lane_renderer: queue-based lane model, miss and pixel monitor.
module tb_note_lane_renderer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       update = 1'b1;
  logic [3:0] speed = '0;
  logic       spawn_valid = 1'b0;
  logic [1:0] spawn_lane = '0;
  logic       spawn_ready, miss_valid;
  logic [3:0] miss_mask;
  logic [7:0] red, green, blue;

  int checks = 0;
  int failures = 0;

  int          lq[4][$];
  logic [3:0]  exp_miss[$];
  logic [23:0] exp_pix[$];
  logic        probe = 1'b0;
  logic        probe_d = 1'b0;

  localparam logic [23:0] COL [4] = '{24'h800080, 24'h00FFFF, 24'h00FF00, 24'hFF0000};
  localparam logic [23:0] BG = 24'h202020;

  note_lane_renderer #(
    .LANES   (4),
    .SLOTS   (8),
    .LANE_X0 (192),
    .LANE_W  (64),
    .ARROW_H (32),
    .SPAWN_Y (480)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .update      (update),
    .speed       (speed),
    .spawn_valid (spawn_valid),
    .spawn_lane  (spawn_lane),
    .spawn_ready (spawn_ready),
    .miss_valid  (miss_valid),
    .miss_mask   (miss_mask),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  always #10 Clk = ~Clk;
  always @(posedge Clk) probe_d <= probe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  function automatic logic [23:0] model_pix(input int x, input int y);
    int l;
    if (x < 192 || x >= 448) return 24'h0;
    l = (x - 192) / 64;
    for (int i = 0; i < lq[l].size(); i++) begin
      if (lq[l][i] <= y && y < lq[l][i] + 32) return COL[l];
    end
    return BG;
  endfunction

  task automatic model_frame(input int spd);
    logic [3:0] m;
    m = '0;
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < lq[l].size(); i++) begin
        lq[l][i] = (lq[l][i] <= spd) ? 0 : lq[l][i] - spd;
      end
    end
    for (int l = 0; l < 4; l++) begin
      if (lq[l].size() > 0 && lq[l][0] == 0) begin
        void'(lq[l].pop_front());
        m[l] = 1'b1;
      end
    end
    if (m != '0) exp_miss.push_back(m);
  endtask

  // Monitor: miss pulses and probed pixels are checked against queued expectations.
  initial begin
    forever begin
      @(negedge Clk);
      if (miss_valid === 1'b1) begin
        if (exp_miss.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL miss_unexpected: got mask %b expected no miss at %0t", miss_mask, $time);
        end else begin
          chk("miss_mask", 32'(miss_mask), 32'(exp_miss.pop_front()));
        end
      end
      if (probe_d) begin
        if (exp_pix.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pixel_unexpected: no expectation queued at %0t", $time);
        end else begin
          chk("pixel_rgb", {8'h0, red, green, blue}, {8'h0, exp_pix.pop_front()});
        end
      end
    end
  end

  task automatic probe_px(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    exp_pix.push_back(model_pix(x, y));
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic spawn(input int l);
    bit exp;
    exp = (lq[l].size() < 8);
    spawn_lane  = 2'(l);
    spawn_valid = 1'b1;
    #1;
    chk("spawn_ready", 32'(spawn_ready), 32'(exp));
    if (exp) lq[l].push_back(480);
    tick();
    spawn_valid = 1'b0;
  endtask

  task automatic do_frame(input int spd);
    bit exp;
    speed  = 4'(spd);
    update = 1'b1;
    #1;
    chk("ready_rise", 32'(spawn_ready), 32'd0);
    model_frame(spd);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c < 9) chk("ready_busy", 32'(spawn_ready), 32'd0);
    end
    if (spawn_valid) begin
      exp = (lq[spawn_lane].size() < 8);
      #1;
      chk("ready_after_frame", 32'(spawn_ready), 32'(exp));
      if (exp) begin
        lq[spawn_lane].push_back(480);
        tick();
        spawn_valid = 1'b0;
      end
    end
    update = 1'b0;
    tick();
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset released with update already high: no frame may start.
    DrawX = 10'd250;
    DrawY = 10'd100;
    repeat (3) @(posedge Clk);
    #2;
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_rgb", {8'h0, red, green, blue}, 32'h0);
      chk("rst_ready", 32'(spawn_ready), 32'd1);
      chk("rst_miss", 32'(miss_valid), 32'd0);
    end
    update = 1'b0;
    tick();

    // Single lane-2 arrow scrolled to the top at speed 4.
    spawn(2);
    do_frame(4);
    probe_px(320, 475);
    probe_px(320, 476);
    probe_px(320, 490);
    probe_px(320, 507);
    probe_px(320, 508);
    for (int f = 0; f < 119; f++) do_frame(4);
    probe_px(320, 10);

    // Fill lane 0, then hold a 9th spawn across frames until a retire frees a slot.
    for (int i = 0; i < 8; i++) spawn(0);
    spawn_valid = 1'b1;
    spawn_lane  = 2'd0;
    #1;
    chk("full_lane0_ready", 32'(spawn_ready), 32'd0);
    spawn_valid = 1'b0;
    spawn_lane  = 2'd1;
    #1;
    chk("lane1_ready", 32'(spawn_ready), 32'd1);
    spawn_lane  = 2'd0;
    spawn_valid = 1'b1;
    tick();
    for (int f = 0; f < 32; f++) do_frame(15);
    chk("held_spawn_done", 32'(spawn_valid), 32'd0);
    probe_px(200, 0);
    probe_px(200, 479);
    probe_px(200, 480);

    // Speed 0: stationary arrows, queued zeros retire one per frame.
    spawn(1);
    for (int f = 0; f < 10; f++) do_frame(0);
    probe_px(260, 480);
    probe_px(260, 479);

    // Saturation: drive lane-1 arrow to Y=3, then speed 5 clamps and retires.
    for (int f = 0; f < 31; f++) do_frame(15);
    do_frame(12);
    probe_px(261, 3);
    probe_px(261, 2);
    probe_px(261, 34);
    probe_px(261, 35);
    do_frame(5);
    probe_px(261, 3);

    // Spawn asserted in the update_rise cycle is accepted on the first IDLE cycle.
    spawn_lane  = 2'd3;
    spawn_valid = 1'b1;
    do_frame(3);
    probe_px(400, 480);
    probe_px(400, 479);

    // Randomized mix of spawns, frames and pixel probes.
    for (int it = 0; it < 300; it++) begin
      int op;
      int l;
      int x;
      int y;
      op = int'($urandom_range(0, 9));
      if (op < 4) begin
        spawn(int'($urandom_range(0, 3)));
      end else if (op < 6) begin
        do_frame(int'($urandom_range(0, 15)));
      end else begin
        l = int'($urandom_range(0, 3));
        x = 192 + l * 64 + int'($urandom_range(0, 63));
        if ($urandom_range(0, 4) == 0) x = int'($urandom_range(100, 550));
        if (lq[l].size() > 0)
          y = lq[l][$urandom_range(0, lq[l].size() - 1)] + int'($urandom_range(0, 35)) - 2;
        else
          y = int'($urandom_range(0, 520));
        if (y < 0) y = 0;
        probe_px(x, y);
      end
    end

    // Reset during MOVE: lanes emptied, frame aborted, no miss pulse.
    spawn(0);
    spawn(1);
    speed  = 4'd15;
    update = 1'b1;
    tick();
    tick();
    tick();
    Reset = 1'b1;
    #1;
    for (int l = 0; l < 4; l++) lq[l].delete();
    tick();
    chk("reset_mid_rgb", {8'h0, red, green, blue}, 32'h0);
    chk("reset_mid_miss", 32'(miss_valid), 32'd0);
    Reset = 1'b0;
    tick();
    update = 1'b0;
    tick();
    for (int l = 0; l < 4; l++) begin
      spawn_lane = 2'(l);
      #1;
      chk("post_reset_ready", 32'(spawn_ready), 32'd1);
      probe_px(192 + l * 64 + 20, 480);
      probe_px(192 + l * 64 + 40, 100);
    end
    do_frame(15);
    probe_px(191, 100);
    probe_px(448, 100);

    repeat (3) tick();
    chk("miss_queue_drained", 32'(exp_miss.size()), 32'd0);
    chk("pixel_queue_drained", 32'(exp_pix.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
